// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between instruction fetch (read
// only) and the MEM stage (load/store). MEM normally wins contention; IF is
// forced through after STARVE_MAX consecutive contended losses. Read data comes
// back one cycle after the grant and is steered to whichever side owned it.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_wdata,
  output logic        mem_gnt,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        ram_en,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    RET_NONE   = 2'd0,
    RET_IF     = 2'd1,
    RET_MEM_LD = 2'd2,
    RET_MEM_ST = 2'd3
  } ret_owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  ret_owner_e ret_owner_q, ret_owner_d;
  logic [3:0] starve_q, starve_d;

  // Pick at most one winner; IF only beats MEM once its loss budget is spent.
  // Reset suppresses both grants so nothing reaches the RAM while held.
  always_comb begin
    if_gnt  = 1'b0;
    mem_gnt = 1'b0;
    if (!reset) begin
      if (if_req && (!mem_req || starve_q == STARVE_LIM)) if_gnt  = 1'b1;
      else if (mem_req)                                   mem_gnt = 1'b1;
    end
  end

  // Drive the RAM from the winning requester; idle cycles present all zeros.
  always_comb begin
    ram_en    = if_gnt | mem_gnt;
    ram_addr  = 32'h0;
    ram_wen   = 4'b0000;
    ram_wdata = 32'h0;
    if (mem_gnt) begin
      ram_addr  = mem_addr;
      ram_wen   = mem_wen;
      ram_wdata = mem_wdata;
    end else if (if_gnt) begin
      ram_addr  = if_addr;
    end
  end

  // Next-state: remember who owns next cycle's return, and count IF losses.
  always_comb begin
    ret_owner_d = RET_NONE;
    if (if_gnt)                         ret_owner_d = RET_IF;
    else if (mem_gnt && mem_wen == 4'b0) ret_owner_d = RET_MEM_LD;
    else if (mem_gnt)                   ret_owner_d = RET_MEM_ST;

    starve_d = starve_q;
    if (!if_req || if_gnt)                       starve_d = 4'd0;
    else if (mem_gnt && starve_q != STARVE_LIM)  starve_d = starve_q + 4'd1;
  end

  // State registers; reset drops any return that was in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ret_owner_q <= RET_NONE;
      starve_q    <= 4'd0;
    end else begin
      ret_owner_q <= ret_owner_d;
      starve_q    <= starve_d;
    end
  end

  // Steer returning read data; stores complete without data.
  always_comb begin
    if_rvalid = (ret_owner_q == RET_IF);
    mem_done  = (ret_owner_q == RET_MEM_LD) || (ret_owner_q == RET_MEM_ST);
    if_rdata  = (ret_owner_q == RET_IF)     ? ram_rdata : 32'h0;
    mem_rdata = (ret_owner_q == RET_MEM_LD) ? ram_rdata : 32'h0;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port synchronous data/instruction RAM between the instruction-fetch requester (read-only) and the MEM-stage requester (load/store with byte write enables). It sits between the IF and MEM pipeline stages and the shared RAM. It issues at most one RAM access per cycle and routes the one-cycle-delayed read data back to the owner. It enforces MEM priority with a bounded-starvation guarantee for IF.

## Interface
- STARVE_MAX, 4: maximum number of consecutive contended cycles IF may lose before it is forced a grant; legal range 0..15.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  IF read request; held with if_addr stable until if_gnt.
- if_addr  in  32  IF read address.
- if_gnt  out  1  IF access issued to RAM this cycle (combinational).
- if_rvalid  out  1  IF read data valid (registered, one cycle after if_gnt).
- if_rdata  out  32  IF read data; 0 when if_rvalid=0.
- mem_req  in  1  MEM access request; held with address/data/wen stable until mem_gnt.
- mem_addr  in  32  MEM access address.
- mem_wen  in  4  byte write enables; 4'b0000 = load.
- mem_wdata  in  32  store data, already lane-aligned by MEM.
- mem_gnt  out  1  MEM access issued this cycle (combinational).
- mem_done  out  1  MEM access complete (registered, one cycle after mem_gnt, loads and stores).
- mem_rdata  out  32  load data; 0 unless mem_done for a load.
- ram_en  out  1  RAM access enable.
- ram_addr  out  32  RAM address.
- ram_wen  out  4  RAM byte write enables.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data; valid the cycle after the address edge.

## Operation
- Grant logic, combinational per cycle:
  - Only if_req: if_gnt=1.
  - Only mem_req: mem_gnt=1.
  - Both: mem_gnt=1 unless starve_cnt==STARVE_MAX, in which case if_gnt=1.
  - Never both grants at once.
- RAM drive:
  - ram_en=if_gnt|mem_gnt.
  - ram_addr=mem_addr on mem_gnt, if_addr on if_gnt, else 0.
  - ram_wen=mem_wen on mem_gnt, else 4'b0000.
  - ram_wdata=mem_wdata on mem_gnt, else 0.
- Return-owner register ret_owner in {NONE, IF, MEM_LD, MEM_ST}:
  - Loaded every edge from the grant: IF on if_gnt, MEM_LD on mem_gnt with wen=0, MEM_ST on mem_gnt with wen≠0, else NONE.
  - if_rvalid=(ret_owner==IF).
  - mem_done=(ret_owner==MEM_LD|MEM_ST).
  - ram_rdata is routed to if_rdata or mem_rdata only for IF or MEM_LD respectively; 0 otherwise.
- Starvation counter starve_cnt, width 4:
  - +1 on each edge where mem_gnt=1 and if_req=1.
  - Cleared to 0 on if_gnt or when if_req=0.
  - Saturates at STARVE_MAX.
  - STARVE_MAX=0: IF wins every contention.
- Addresses are passed through unchecked; alignment is the requester's responsibility.

## Timing
- Reset, asynchronous: ret_owner=NONE and starve_cnt=0 immediately.
  - if_rvalid, mem_done, if_rdata and mem_rdata become 0 at reset assertion.
  - Grants and ram_* outputs follow the inputs combinationally, but are forced to 0 while reset=1.
- Latency: grant in cycle T; rvalid/done and data in cycle T+1.
- Throughput: one access per cycle; back-to-back grants are allowed. A new grant in T+1 coexists with the return of T.
- A grant while a return is in flight is legal; the return always belongs to the previous-cycle grant.
- Reset mid-operation: a pending return is discarded; no rvalid/done in the first cycle after reset deassertion.
- A requester dropping req before grant is a protocol violation; behaviour is undefined, and the assertion bench flags it.

## Test plan
- Reset mid-read:
  - Stimulus: if_req=1, if_addr=0x100 granted at T, reset asserted at T+0.5 and deasserted at T+2.
  - Required: if_rvalid is never 1; starve_cnt=0; no ram_en during reset.
- Single IF read:
  - Stimulus: if_req=1, if_addr=0x0000_0040, RAM returns 0x2402_0001.
  - Required: if_gnt and ram_en in T, ram_addr=0x40, ram_wen=0; if_rvalid=1 and if_rdata=0x2402_0001 in T+1.
- Store then load back-to-back:
  - Stimulus: MEM store with wen=4'b0100, addr=0x82, wdata=0x00AB_0000 at T; load from addr 0x80 at T+1.
  - Required: ram_wen=4'b0100 in T; mem_done in T+1 with mem_rdata=0 (store); mem_done in T+2 with mem_rdata=ram_rdata.
- Contention, STARVE_MAX=2:
  - Stimulus: if_req and mem_req held high for 6 cycles.
  - Required grant sequence: MEM, MEM, IF, MEM, MEM, IF; starve_cnt sequence 0,1,2,0,1,2.
- STARVE_MAX=0 contention:
  - Stimulus: both requests high.
  - Required: if_gnt every contended cycle and mem_gnt only when if_req=0.
- IF request dropped:
  - Stimulus: if_req drops after 1 contended loss.
  - Required: starve_cnt returns to 0 on the next edge; a later contention starts the count from 0.
